// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_pkg
//  Description : Shared keypad constants, event record and serializer states.
//  Revision    : 1.0 - initial release
// ============================================================================
package keypad_pkg;

    localparam int NUM_KEYS = 25;
    localparam int NUM_ROWS = 5;
    localparam int NUM_COLS = 5;
    localparam int KEY_W    = 5;
    localparam int CNT_W    = 4;

    typedef struct packed {
        logic             press;
        logic [KEY_W-1:0] key;
    } key_event_t;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } ser_state_t;

endpackage
`default_nettype wire

// File: rtl/keypad_event_encoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_event_encoder_if
//  Description : Raw frame input and press/release event stream bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
interface keypad_event_encoder_if #(
    parameter int NUM_KEYS = 25
);
    import keypad_pkg::*;

    logic                frame_valid;
    logic [NUM_KEYS-1:0] frame;
    logic                ev_valid;
    logic                ev_ready;
    logic [KEY_W-1:0]    ev_key;
    logic                ev_press;
    logic                overflow;

    // master: frame producer and event consumer; slave: the encoder
    modport master (
        output frame_valid, frame, ev_ready,
        input  ev_valid, ev_key, ev_press, overflow
    );

    modport slave (
        input  frame_valid, frame, ev_ready,
        output ev_valid, ev_key, ev_press, overflow
    );

endinterface
`default_nettype wire

// File: rtl/keypad_event_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_event_fifo
//  Description : First-word-fall-through FIFO; head valid whenever not empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module keypad_event_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);
    localparam int c_ptr_w = $clog2(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign o_full    = (r_count == (c_ptr_w+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    // a pop in the same cycle frees the slot, so a full FIFO still accepts
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            if (w_do_push && !w_do_pop)
                r_count <= r_count + (c_ptr_w+1)'(1);
            else if (!w_do_push && w_do_pop)
                r_count <= r_count - (c_ptr_w+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
    end

endmodule
`default_nettype wire

// File: rtl/keypad_event_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_event_encoder
//  Description : Per-key frame debouncer feeding a press/release event FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module keypad_event_encoder #(
    parameter int NUM_KEYS        = 25,
    parameter int DEBOUNCE_FRAMES = 4,
    parameter int FIFO_DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    keypad_event_encoder_if.slave bus
);
    import keypad_pkg::*;

    localparam logic [CNT_W-1:0] c_db_last = CNT_W'(DEBOUNCE_FRAMES - 1);

    logic [NUM_KEYS-1:0] r_stable;
    logic [NUM_KEYS-1:0] r_pending;
    logic [CNT_W-1:0]    r_count [NUM_KEYS];
    logic [NUM_KEYS-1:0] w_accept;
    logic [NUM_KEYS-1:0] w_clear;
    logic                w_hit;
    logic [KEY_W-1:0]    w_sel;
    ser_state_t          r_state;
    logic                r_overflow;
    key_event_t          w_push_ev;
    key_event_t          w_head;
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;

    always_comb begin
        w_accept = '0;
        for (int k = 0; k < NUM_KEYS; k++)
            w_accept[k] = bus.frame_valid && (bus.frame[k] != r_stable[k])
                          && (r_count[k] == c_db_last);
    end

    // lowest pending index wins; scanned high-to-low so the last hit sticks
    always_comb begin
        w_hit = 1'b0;
        w_sel = '0;
        for (int k = NUM_KEYS - 1; k >= 0; k--) begin
            if (r_pending[k]) begin
                w_hit = 1'b1;
                w_sel = KEY_W'(k);
            end
        end
    end

    assign w_push    = (r_state == ST_DRAIN) && w_hit;
    assign w_pop     = bus.ev_ready && !w_empty;
    assign w_push_ev = {r_stable[w_sel], w_sel};

    always_comb begin
        w_clear = '0;
        if (w_push) w_clear[w_sel] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stable  <= '0;
            r_pending <= '0;
            for (int k = 0; k < NUM_KEYS; k++) r_count[k] <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clear) | w_accept;
            r_stable  <= r_stable ^ w_accept;
            if (bus.frame_valid) begin
                for (int k = 0; k < NUM_KEYS; k++) begin
                    if ((bus.frame[k] == r_stable[k]) || w_accept[k])
                        r_count[k] <= '0;
                    else
                        r_count[k] <= r_count[k] + CNT_W'(1);
                end
            end
        end
    end

    // entering DRAIN on the accepting frame lets the first push land one edge later
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_overflow <= 1'b0;
        end else begin
            if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
            case (r_state)
                ST_IDLE:
                    if ((w_accept != '0) || (r_pending != '0)) r_state <= ST_DRAIN;
                ST_DRAIN:
                    if (((r_pending & ~w_clear) == '0) && (w_accept == '0))
                        r_state <= ST_IDLE;
                default:
                    r_state <= ST_IDLE;
            endcase
        end
    end

    keypad_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(key_event_t))
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (w_push_ev),
        .i_pop       (bus.ev_ready),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    assign bus.ev_valid = !w_empty;
    assign bus.ev_key   = w_empty ? '0   : w_head.key;
    assign bus.ev_press = w_empty ? 1'b0 : w_head.press;
    assign bus.overflow = r_overflow;

endmodule
`default_nettype wire

// File: doc/keypad_event_encoder.md
# keypad_event_encoder

Consumer end of the keypad scan interface. It takes the 25-bit per-frame button snapshot produced by the row/column keypad scanner and debounces every key across frames. Each debounced state change becomes a single press/release event, queued in a small FIFO and offered on a valid/ready stream to downstream logic such as LED display, UART report or a soft CPU. The LED-only output path is replaced by a lossless event stream covering all 25 keys.

## Interface
- NUM_KEYS, 25: keys per frame; key index = row*5 + col.
- DEBOUNCE_FRAMES, 4: consecutive differing frames required to accept a change; legal range 1..15.
- FIFO_DEPTH, 8: event queue depth; power of two, at least 2.

- clk  in  1  system clock (200 MHz single-ended, from the clock wizard).
- rst  in  1  asynchronous, active-high reset.
- frame_valid  in  1  one-cycle strobe, raw frame complete.
- frame  in  NUM_KEYS  raw key state, 1 = pressed; sampled only when frame_valid = 1.
- ev_valid  out  1  event available.
- ev_ready  in  1  downstream accepts event.
- ev_key  out  5  key index of the head event.
- ev_press  out  1  1 = press, 0 = release.
- overflow  out  1  sticky; an event was dropped because the FIFO was full.

## Operation
- Per-key state:
  - stable bit, reset 0 (released).
  - counter of width 4, reset 0.
  - pending bit, reset 0.
- Debounce update, on each frame_valid, for every key k:
  - frame[k] == stable[k]: counter cleared.
  - Otherwise, counter < DEBOUNCE_FRAMES-1: counter incremented.
  - Otherwise, counter == DEBOUNCE_FRAMES-1: stable[k] toggles, counter cleared, pending[k] set.
- Serializer FSM, states IDLE and DRAIN:
  - IDLE goes to DRAIN when any pending bit is set.
  - In DRAIN, each cycle takes the lowest-index pending key k and clears pending[k].
  - It writes {press = stable[k], key = k} to the FIFO.
  - If the FIFO is full and not popping in the same cycle, the event is dropped and overflow is set. The serializer never stalls.
  - DRAIN returns to IDLE when pending is all zero.
- Frame spacing guarantee: frame_valid strobes are at least NUM_KEYS+2 cycles apart (the scanner period is 200000 cycles). Pending therefore always drains before the next frame, and stable cannot change again before its event is queued.
- FIFO is first-word-fall-through:
  - ev_valid = not empty; ev_key/ev_press show the head entry.
  - Pop when ev_valid && ev_ready.
  - Push and pop in the same cycle while full: both succeed, no drop, no overflow.
- Handshake: once ev_valid is asserted, it and ev_key/ev_press stay constant until accepted.
- overflow is cleared only by rst.
- rst asserted at any time, including mid-drain:
  - All state returns immediately to reset values and the FIFO empties.
  - Outputs: ev_valid = 0, ev_key = 0, ev_press = 0, overflow = 0.
  - A key still held after reset produces a press event after DEBOUNCE_FRAMES frames.

## Timing
- frame_valid is sampled at edge t. stable and pending update at edge t.
- The first event is written to the FIFO at edge t+1, and ev_valid is high from edge t+1.
- N simultaneous changes with ev_ready held at 1: events appear on consecutive cycles in ascending key order. The last one is presented from edge t+N.
- Debounce latency: an accepted change requires DEBOUNCE_FRAMES frame_valid strobes. DEBOUNCE_FRAMES = 1 means an event on the first differing frame.
- The FIFO output registers add no extra cycle: head data is valid in the same cycle as ev_valid.

## Structure
- Shared package keypad_pkg holds:
  - constants NUM_KEYS = 25, NUM_ROWS = 5, NUM_COLS = 5, KEY_W = 5.
  - event typedef {press, key[4:0]}.
- The scanner also uses keypad_pkg.
- Sub-module keypad_event_fifo: synchronous FWFT FIFO with parameterised DEPTH/WIDTH, full and empty flags, and asynchronous rst.
- Debounce array and priority-encoder serializer stay in the top of this block.

## Test plan
- Key 7:
  - Raw frames 1,1,1,1 with DEBOUNCE_FRAMES = 4.
  - Required: exactly one event, key = 7, press = 1, ev_valid high from the edge after the 4th frame_valid.
  - Then frames 0 ×4: one event, key = 7, press = 0.
- Bounce on key 3:
  - Raw frames 1,0,1,1,1,1.
  - Required: no event until the 6th frame, then a single press.
  - Total events = 1.
- Simultaneous keys:
  - Keys 24, 0, 12 change to pressed in the same frames, with ev_ready = 1.
  - Required: events key 0, 12, 24, all press = 1, on three consecutive cycles.
- Backpressure/overflow:
  - ev_ready = 0 and FIFO_DEPTH = 8.
  - Keys 0..9 are pressed together.
  - Required: the FIFO holds keys 0..7, keys 8 and 9 are dropped, and overflow = 1.
  - Then ev_ready = 1: events 0..7 drain in order, and overflow stays 1.
- Reset mid-drain:
  - Assert rst while 3 events are pending, with key 5 still held in raw frames.
  - Required: ev_valid = 0 and overflow = 0 during reset.
  - After release: exactly one press for key 5, after 4 frames.
- Full with simultaneous push and pop:
  - FIFO full, ev_ready = 1, and a new change is queued in the same cycle.
  - Required: no drop, overflow stays 0, and occupancy stays 8.
